// File: rtl/instruction_fifo_if.sv
// Handshake bundle between an instruction producer/consumer and instruction_fifo.
// data_count exists only when INSTR_FIFO_COUNT_EN is defined.
interface instruction_fifo_if #(
    parameter int DATA_W = 147,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              full;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              empty;
`ifdef INSTR_FIFO_COUNT_EN
    logic [ADDR_W:0]   data_count;
`endif

    modport master (
        output wr_en, din, rd_en,
        input  full, dout, empty
`ifdef INSTR_FIFO_COUNT_EN
        , input data_count
`endif
    );

    modport slave (
        input  wr_en, din, rd_en,
        output full, dout, empty
`ifdef INSTR_FIFO_COUNT_EN
        , output data_count
`endif
    );
endinterface

// File: rtl/instruction_fifo.sv
// Single-clock standard-mode FIFO for 147-bit instruction words; dout is registered one cycle after an accepted read.
// Optional occupancy output enabled by defining INSTR_FIFO_COUNT_EN.
module instruction_fifo #(
    parameter int DATA_W = 147,
    parameter int DEPTH  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fifo_if.slave   bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   rptr_q, rptr_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic empty;
    logic full;
    logic wr_accept;
    logic rd_accept;

    // The extra pointer MSB distinguishes a full buffer from an empty one when the low bits match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                   (wptr_q[ADDR_W] != rptr_q[ADDR_W]);

    assign wr_accept = bus.wr_en && !full;
    assign rd_accept = bus.rd_en && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        dout_d = dout_q;
        if (wr_accept) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rptr_d = rptr_q + PTR_ONE;
            dout_d = mem_q[rptr_q[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            dout_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            dout_q <= dout_d;
        end
    end

    // Storage is not reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= bus.din;
        end
    end

    assign bus.dout  = dout_q;
    assign bus.empty = empty;
    assign bus.full  = full;

`ifdef INSTR_FIFO_COUNT_EN
    assign bus.data_count = wptr_q - rptr_q;
`endif

endmodule

// File: tb/tb_instruction_fifo.sv
// Self-checking bench for instruction_fifo using a queue scoreboard of expected read data.
// Occupancy checks are included when INSTR_FIFO_COUNT_EN is defined.
module tb_instruction_fifo;
    localparam int DATA_W = 147;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    logic clk;
    logic rst_n;

    instruction_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    instruction_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compare_count  = 0;
    int mismatch_count = 0;

    logic [DATA_W-1:0] scoreboard [$];
    logic [DATA_W-1:0] exp_dout;

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".dout"}, bus.dout, exp_dout);
        checkOutput({tag, ".empty"}, DATA_W'(bus.empty), DATA_W'(scoreboard.size() == 0));
        checkOutput({tag, ".full"}, DATA_W'(bus.full), DATA_W'(scoreboard.size() == DEPTH));
`ifdef INSTR_FIFO_COUNT_EN
        checkOutput({tag, ".count"}, DATA_W'(bus.data_count), DATA_W'(scoreboard.size()));
`endif
    endtask

    // Drives one cycle of stimulus (called at posedge+1) and checks the result at the next posedge+1.
    task automatic applyStimulus(input string tag, input logic wr, input logic [DATA_W-1:0] data,
                                 input logic rd);
        bit wr_ok;
        bit rd_ok;
        wr_ok = wr && (scoreboard.size() < DEPTH);
        rd_ok = rd && (scoreboard.size() > 0);
        bus.wr_en = wr;
        bus.din   = data;
        bus.rd_en = rd;
        @(posedge clk);
        #1;
        if (rd_ok) exp_dout = scoreboard.pop_front();
        if (wr_ok) scoreboard.push_back(data);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        checkState(tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] word;
        word = 147'h1_2345_6789_ABCD_EF01_2345_6789_ABCD;
        exp_dout  = '0;
        rst_n     = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;

        repeat (3) @(posedge clk);
        #2;
        checkState("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single word");
        applyStimulus("single_wr", 1'b1, word, 1'b0);
        applyStimulus("single_rd", 1'b0, '0, 1'b1);
        applyStimulus("single_idle", 1'b0, '0, 1'b0);

        $display("[TB] fill and overflow");
        for (int i = 0; i < DEPTH; i++) applyStimulus("fill_wr", 1'b1, DATA_W'(i), 1'b0);
        applyStimulus("overflow_wr", 1'b1, DATA_W'(99), 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus("fill_rd", 1'b0, '0, 1'b1);
        applyStimulus("underflow_rd", 1'b0, '0, 1'b1);

        $display("[TB] pointer wrap");
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) applyStimulus("wrap_wr", 1'b1, DATA_W'(r * 10 + i), 1'b0);
            for (int i = 0; i < 10; i++) applyStimulus("wrap_rd", 1'b0, '0, 1'b1);
        end

        $display("[TB] simultaneous read and write");
        for (int i = 0; i < 5; i++) applyStimulus("sim_pre", 1'b1, DATA_W'(100 + i), 1'b0);
        applyStimulus("sim_mid", 1'b1, DATA_W'(200), 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus("sim_drain", 1'b0, '0, 1'b1);
        applyStimulus("sim_empty", 1'b1, DATA_W'(300), 1'b1);
        applyStimulus("sim_empty_rd", 1'b0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) applyStimulus("sim_fill", 1'b1, DATA_W'(400 + i), 1'b0);
        applyStimulus("sim_full", 1'b1, DATA_W'(999), 1'b1);
        applyStimulus("sim_full_wr", 1'b1, DATA_W'(500), 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus("sim_full_drain", 1'b0, '0, 1'b1);

        $display("[TB] async reset mid-burst");
        for (int i = 0; i < 6; i++) applyStimulus("rst_pre", 1'b1, {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
        applyStimulus("rst_pre_rd", 1'b0, '0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        scoreboard.delete();
        exp_dout = '0;
        checkState("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkState("post_rst");
        applyStimulus("post_rst_rd", 1'b0, '0, 1'b1);
        applyStimulus("post_rst_wr", 1'b1, word, 1'b0);
        applyStimulus("post_rst_rd2", 1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end
endmodule
